// File: rtl/microcontrolador_nios2_cpu_debug_action_sched.sv
// Debug action scheduler: queues debug-slave action strobes with their JTAG word and
// issues them in order over a valid/ready port, halt-gating OCI memory actions with a timeout.
module microcontrolador_nios2_cpu_debug_action_sched #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [5:0]    act_strobe,
   input  logic [37:0]   jdo,
   input  logic          debugack,
   output logic          cmd_valid,
   output logic [2:0]    cmd_type,
   output logic [37:0]   cmd_data,
   input  logic          cmd_ready,
   output logic [AW:0]   level,
   output logic [2:0]    status,
   input  logic          status_clr,
   output logic          timeout_pulse
);

   typedef enum logic [1:0] {IDLE, GATE, ISSUE} state_t;

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);

   state_t        state_reg, state_next;
   logic [40:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   level_reg, level_next;
   logic [15:0]   cnt_reg, cnt_next;
   logic [2:0]    status_reg, status_next;
   logic          cmd_valid_reg, timeout_pulse_reg;
   logic [2:0]    cmd_type_reg;
   logic [37:0]   cmd_data_reg;

   logic [2:0]    push_type;
   logic          push, push_ok, pop, multi, full;
   logic          head_gated, to_pop, accept, load_head;
   logic [40:0]   head;

   // Lowest set strobe bit wins; scan from the top so the last hit is the lowest.
   always_comb begin
      push_type = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (act_strobe[i]) push_type = 3'(i);
      end
   end

   assign push       = |act_strobe;
   assign multi      = |(act_strobe & (act_strobe - 6'd1));
   assign full       = (level_reg == FULL_LVL);
   assign head       = mem[rd_ptr_reg];
   assign head_gated = (head[40:39] == 2'b00);
   assign accept     = (state_reg == ISSUE) && cmd_valid_reg && cmd_ready;
   assign pop        = accept || to_pop;
   assign push_ok    = push && (!full || pop);
   assign level_next = level_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
   assign load_head  = (state_next == ISSUE) && (state_reg != ISSUE);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      to_pop     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (level_reg != '0) begin
               if (head_gated && !debugack) begin
                  state_next = GATE;
                  cnt_next   = 16'd0;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         GATE: begin
            if (debugack) begin
               state_next = ISSUE;
            end else if (cnt_reg == TO_LIM) begin
               to_pop     = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 16'd1;
            end
         end
         ISSUE: begin
            if (accept) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A set event in the same cycle as a clear survives the clear.
   assign status_next = (status_clr ? 3'b000 : status_reg)
                      | {to_pop, push && multi, push && full && !pop};

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= {push_type, jdo};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg         <= IDLE;
         wr_ptr_reg        <= '0;
         rd_ptr_reg        <= '0;
         level_reg         <= '0;
         cnt_reg           <= '0;
         status_reg        <= '0;
         cmd_valid_reg     <= 1'b0;
         cmd_type_reg      <= '0;
         cmd_data_reg      <= '0;
         timeout_pulse_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         cnt_reg           <= cnt_next;
         level_reg         <= level_next;
         status_reg        <= status_next;
         timeout_pulse_reg <= to_pop;
         cmd_valid_reg     <= (state_next == ISSUE);
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (load_head) begin
            cmd_type_reg <= head[40:38];
            cmd_data_reg <= head[37:0];
         end
      end
   end

   assign cmd_valid     = cmd_valid_reg;
   assign cmd_type      = cmd_type_reg;
   assign cmd_data      = cmd_data_reg;
   assign level         = level_reg;
   assign status        = status_reg;
   assign timeout_pulse = timeout_pulse_reg;

endmodule

// File: tb/tb_microcontrolador_nios2_cpu_debug_action_sched.sv
// Directed bench for the debug action scheduler (DEPTH=4, TIMEOUT=15).
module tb_microcontrolador_nios2_cpu_debug_action_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [5:0]  act_strobe;
   logic [37:0] jdo;
   logic        debugack;
   logic        cmd_valid;
   logic [2:0]  cmd_type;
   logic [37:0] cmd_data;
   logic        cmd_ready;
   logic [2:0]  level;
   logic [2:0]  status;
   logic        status_clr;
   logic        timeout_pulse;

   int total = 0;
   int bad   = 0;

   microcontrolador_nios2_cpu_debug_action_sched #(
      .DEPTH(4), .AW(2), .TIMEOUT(15)
   ) dut (
      .clk(clk), .reset_n(reset_n), .act_strobe(act_strobe), .jdo(jdo),
      .debugack(debugack), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
      .cmd_data(cmd_data), .cmd_ready(cmd_ready), .level(level),
      .status(status), .status_clr(status_clr), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push(input int t, input logic [37:0] d);
      act_strobe = 6'b000001 << t;
      jdo        = d;
      tick();
      act_strobe = 6'b0;
   endtask

   logic [2:0]  got_t [$];
   logic [37:0] got_d [$];
   logic [2:0]  exp_ord [4] = '{3'd5, 3'd4, 3'd3, 3'd2};
   int          valid_seen;
   int          pulse_seen;

   initial begin
      reset_n = 1'b0; act_strobe = '0; jdo = '0; debugack = 1'b0;
      cmd_ready = 1'b0; status_clr = 1'b0;
      tick(); tick();
      chk("rst_valid", 64'(cmd_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_status", 64'(status), 64'd0);
      chk("rst_data", 64'(cmd_data), 64'd0);
      reset_n = 1'b1;
      tick();

      // Basic issue
      cmd_ready = 1'b1;
      push(2, 38'h12_3456_789A);
      chk("basic_level1", 64'(level), 64'd1);
      chk("basic_novalid_yet", 64'(cmd_valid), 64'd0);
      tick();
      chk("basic_valid", 64'(cmd_valid), 64'd1);
      chk("basic_type", 64'(cmd_type), 64'd2);
      chk("basic_data", 64'(cmd_data), 64'h12_3456_789A);
      tick();
      chk("basic_drop_valid", 64'(cmd_valid), 64'd0);
      chk("basic_level0", 64'(level), 64'd0);
      tick();
      chk("basic_one_cycle", 64'(cmd_valid), 64'd0);

      // Ordering and overflow
      cmd_ready = 1'b0;
      push(5, 38'h105);
      push(4, 38'h104);
      push(3, 38'h103);
      push(2, 38'h102);
      push(0, 38'h100);
      chk("ovf_level", 64'(level), 64'd4);
      chk("ovf_status", 64'(status), 64'b001);
      chk("ovf_head_type", 64'(cmd_type), 64'd5);
      cmd_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (cmd_valid) begin
            got_t.push_back(cmd_type);
            got_d.push_back(cmd_data);
         end
         tick();
      end
      chk("ord_count", 64'(got_t.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ord_type%0d", i), 64'(got_t[i]), 64'(exp_ord[i]));
         chk($sformatf("ord_data%0d", i), 64'(got_d[i]), 64'(38'h100 + 38'(exp_ord[i])));
      end
      chk("ord_level0", 64'(level), 64'd0);
      status_clr = 1'b1; tick(); status_clr = 1'b0;
      chk("ovf_clr", 64'(status), 64'd0);

      // Collision
      cmd_ready = 1'b0; debugack = 1'b1;
      act_strobe = 6'b101010; jdo = 38'h2A_0000_0001;
      tick();
      act_strobe = 6'b0;
      chk("col_level", 64'(level), 64'd1);
      chk("col_status", 64'(status), 64'b010);
      tick();
      chk("col_type", 64'(cmd_type), 64'd1);
      chk("col_data", 64'(cmd_data), 64'h2A_0000_0001);
      status_clr = 1'b1; tick(); status_clr = 1'b0;
      chk("col_clr", 64'(status), 64'd0);
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      chk("col_drained", 64'(level), 64'd0);
      // Set wins over clear in the same cycle
      act_strobe = 6'b000011; jdo = 38'h7; status_clr = 1'b1;
      tick();
      act_strobe = 6'b0; status_clr = 1'b0;
      chk("set_beats_clr", 64'(status), 64'b010);
      cmd_ready = 1'b1;
      tick(); tick(); tick();
      chk("set_drained", 64'(level), 64'd0);
      status_clr = 1'b1; tick(); status_clr = 1'b0;
      debugack = 1'b0;

      // Halt gate
      valid_seen = 0; pulse_seen = 0;
      push(0, 38'h3F_0000_0000);
      for (int i = 0; i < 10; i++) begin
         if (cmd_valid) valid_seen++;
         if (timeout_pulse) pulse_seen++;
         tick();
      end
      chk("gate_no_valid", 64'(valid_seen), 64'd0);
      chk("gate_level", 64'(level), 64'd1);
      debugack = 1'b1;
      tick();
      chk("gate_valid", 64'(cmd_valid), 64'd1);
      chk("gate_type", 64'(cmd_type), 64'd0);
      chk("gate_data", 64'(cmd_data), 64'h3F_0000_0000);
      tick();
      if (timeout_pulse) pulse_seen++;
      chk("gate_level0", 64'(level), 64'd0);
      chk("gate_no_timeout", 64'(pulse_seen), 64'd0);
      chk("gate_status", 64'(status), 64'd0);
      debugack = 1'b0;

      // Timeout
      valid_seen = 0; pulse_seen = 0;
      push(1, 38'h11);
      push(5, 38'h55);
      for (int i = 0; i < 15; i++) begin
         tick();
         if (cmd_valid) valid_seen++;
         if (timeout_pulse) pulse_seen++;
      end
      chk("to_no_early_pulse", 64'(pulse_seen), 64'd0);
      chk("to_no_valid", 64'(valid_seen), 64'd0);
      tick();
      chk("to_pulse", 64'(timeout_pulse), 64'd1);
      chk("to_status", 64'(status), 64'b100);
      chk("to_level", 64'(level), 64'd1);
      chk("to_valid_off", 64'(cmd_valid), 64'd0);
      tick();
      chk("to_pulse_once", 64'(timeout_pulse), 64'd0);
      chk("to_next_valid", 64'(cmd_valid), 64'd1);
      chk("to_next_type", 64'(cmd_type), 64'd5);
      tick();
      chk("to_level0", 64'(level), 64'd0);
      status_clr = 1'b1; tick(); status_clr = 1'b0;

      // Reset mid-handshake
      cmd_ready = 1'b0;
      push(5, 38'h5);
      push(4, 38'h4);
      push(3, 38'h3);
      chk("mid_level3", 64'(level), 64'd3);
      chk("mid_valid", 64'(cmd_valid), 64'd1);
      reset_n = 1'b0;
      #2;
      chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
      chk("mid_rst_level", 64'(level), 64'd0);
      chk("mid_rst_type", 64'(cmd_type), 64'd0);
      chk("mid_rst_data", 64'(cmd_data), 64'd0);
      chk("mid_rst_status", 64'(status), 64'd0);
      cmd_ready = 1'b1;
      tick(); tick();
      reset_n = 1'b1;
      valid_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (cmd_valid) valid_seen++;
      end
      chk("mid_no_issue", 64'(valid_seen), 64'd0);
      chk("mid_level_after", 64'(level), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
